// File: rtl/lfsr_pkg.sv
// Shared constants, state type and feedback helper for the 8-bit XNOR LFSR
// pattern generator and its receive-side checker.
package lfsr_pkg;

    localparam int          LFSR_W      = 8;
    localparam int          TAP_HI      = 7;
    localparam int          TAP_LO      = 3;
    localparam logic [7:0]  LFSR_LOCKUP = 8'hFF;
    localparam logic [7:0]  LFSR_SEED   = 8'h00;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // Next bit the generator emits from state s (XNOR of the two taps).
    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
        return ~(s[TAP_HI] ^ s[TAP_LO]);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Serial receive bus of lfsr_checker. Optional bit_count is present only when
// LFSR_CHECKER_BITCNT_EN is defined.
interface lfsr_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_bit;
    logic                 clear_cnt;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0]          bit_count;

    modport master (output in_valid, in_bit, clear_cnt,
                    input  locked, err_pulse, err_count, bit_count);
    modport slave  (input  in_valid, in_bit, clear_cnt,
                    output locked, err_pulse, err_count, bit_count);
`else
    modport master (output in_valid, in_bit, clear_cnt,
                    input  locked, err_pulse, err_count);
    modport slave  (input  in_valid, in_bit, clear_cnt,
                    output locked, err_pulse, err_count);
`endif
endinterface

// File: rtl/lfsr_err_window.sv
// Error-density monitor: counts valid bits modulo WINDOW and errors within the
// current window; loss is asserted combinationally on the error reaching LOSS_THRESH.
module lfsr_err_window #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic valid,
    input  logic err,
    output logic loss
);
    localparam int WIN_W = $clog2(WINDOW + 1);

    logic [WIN_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [WIN_W-1:0] err_cnt_r, err_cnt_nxt_s;
    logic             wrap_s;

    assign wrap_s = (bit_cnt_r == WIN_W'(WINDOW - 1));

    // Next window counters; an error on the wrap bit opens the new window at 1.
    always_comb begin
        bit_cnt_nxt_s = bit_cnt_r;
        err_cnt_nxt_s = err_cnt_r;
        if (wrap_s) begin
            bit_cnt_nxt_s = '0;
            err_cnt_nxt_s = WIN_W'(err);
        end else begin
            bit_cnt_nxt_s = bit_cnt_r + WIN_W'(1);
            err_cnt_nxt_s = err_cnt_r + WIN_W'(err);
        end
    end

    assign loss = valid && err && (err_cnt_nxt_s >= WIN_W'(LOSS_THRESH));

    // Window counter registers; restart takes priority over counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
        end else if (restart) begin
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
        end else if (valid) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            err_cnt_r <= err_cnt_r;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit XNOR LFSR stream. Defining
// LFSR_CHECKER_BITCNT_EN adds the bit_count output on the bus.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int VERIFY_LEN  = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    lfsr_checker_if.slave    bus
);
    localparam logic [7:0] VLEN_M1 = 8'(VERIFY_LEN - 1);

    lfsr_state_e          state_r, state_nxt_s;
    logic [LFSR_W-1:0]    sh_r, sh_nxt_s;
    logic [2:0]           fill_r, fill_nxt_s;
    logic [7:0]           run_r, run_nxt_s;
    logic                 locked_r, locked_nxt_s;
    logic                 err_pulse_r, err_pulse_nxt_s;
    logic [ERR_CNT_W-1:0] err_count_r, err_count_nxt_s;
    logic                 pred_s, lock_valid_s, lock_err_s, restart_s, loss_s;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0]          bit_count_r, bit_count_nxt_s;
`endif

    assign pred_s       = lfsr_feedback(sh_r);
    assign lock_valid_s = bus.in_valid && (state_r == LOCKED);
    assign lock_err_s   = lock_valid_s && (bus.in_bit != pred_s);
    assign restart_s    = (state_r != LOCKED) && (state_nxt_s == LOCKED);

    lfsr_err_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_err_window (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart_s),
        .valid   (lock_valid_s),
        .err     (bus.in_bit != pred_s),
        .loss    (loss_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= SEARCH;
            sh_r        <= LFSR_SEED;
            fill_r      <= 3'd0;
            run_r       <= 8'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= '0;
`ifdef LFSR_CHECKER_BITCNT_EN
            bit_count_r <= 32'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            sh_r        <= sh_nxt_s;
            fill_r      <= fill_nxt_s;
            run_r       <= run_nxt_s;
            locked_r    <= locked_nxt_s;
            err_pulse_r <= err_pulse_nxt_s;
            err_count_r <= err_count_nxt_s;
`ifdef LFSR_CHECKER_BITCNT_EN
            bit_count_r <= bit_count_nxt_s;
`endif
        end
    end

    // Next-state: fill, verify, then track the stream on predicted bits.
    always_comb begin
        state_nxt_s = state_r;
        sh_nxt_s    = sh_r;
        fill_nxt_s  = fill_r;
        run_nxt_s   = run_r;
        if (bus.in_valid) begin
            case (state_r)
                SEARCH: begin
                    sh_nxt_s = {sh_r[LFSR_W-2:0], bus.in_bit};
                    if (fill_r == 3'd7) begin
                        fill_nxt_s = 3'd0;
                        if (sh_nxt_s == LFSR_LOCKUP) begin
                            state_nxt_s = SEARCH;
                        end else begin
                            state_nxt_s = VERIFY;
                            run_nxt_s   = 8'd0;
                        end
                    end else begin
                        fill_nxt_s = fill_r + 3'd1;
                    end
                end
                VERIFY: begin
                    sh_nxt_s = {sh_r[LFSR_W-2:0], bus.in_bit};
                    if (bus.in_bit == pred_s) begin
                        run_nxt_s = run_r + 8'd1;
                        if (run_r == VLEN_M1) begin
                            state_nxt_s = LOCKED;
                        end else begin
                            state_nxt_s = VERIFY;
                        end
                    end else begin
                        state_nxt_s = SEARCH;
                        fill_nxt_s  = 3'd0;
                    end
                end
                LOCKED: begin
                    sh_nxt_s = {sh_r[LFSR_W-2:0], pred_s};
                    if (loss_s) begin
                        state_nxt_s = SEARCH;
                        fill_nxt_s  = 3'd0;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = SEARCH;
                    fill_nxt_s  = 3'd0;
                    run_nxt_s   = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output and counter next values; clear_cnt beats a same-cycle error.
    always_comb begin
        locked_nxt_s    = (state_nxt_s == LOCKED);
        err_pulse_nxt_s = lock_err_s;
        err_count_nxt_s = err_count_r;
        if (bus.clear_cnt) begin
            err_count_nxt_s = '0;
        end else if (lock_err_s && (err_count_r != '1)) begin
            err_count_nxt_s = err_count_r + ERR_CNT_W'(1);
        end else begin
            err_count_nxt_s = err_count_r;
        end
`ifdef LFSR_CHECKER_BITCNT_EN
        bit_count_nxt_s = bit_count_r;
        if (bus.clear_cnt) begin
            bit_count_nxt_s = 32'd0;
        end else if (lock_valid_s && (bit_count_r != 32'hFFFF_FFFF)) begin
            bit_count_nxt_s = bit_count_r + 32'd1;
        end else begin
            bit_count_nxt_s = bit_count_r;
        end
`endif
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_count_r;
`ifdef LFSR_CHECKER_BITCNT_EN
    assign bus.bit_count = bit_count_r;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: acquisition, errors, loss/relock, lockup,
// verify failure, input gaps, reset and clear.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] gen_r = 8'h00;
    int         total_cnt = 0;
    int         pass_cnt = 0;
    int         pulse_cnt = 0;
    int         lock_seen = 0;

    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_CNT_W(16)) bus ();

    lfsr_checker #(
        .VERIFY_LEN  (16),
        .WINDOW      (64),
        .LOSS_THRESH (4),
        .ERR_CNT_W   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic b);
        bus.in_valid = v;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        if (bus.err_pulse) pulse_cnt++;
        if (bus.locked) lock_seen++;
    endtask

    task automatic gen_next(output logic fb);
        fb    = ~(gen_r[7] ^ gen_r[3]);
        gen_r = {gen_r[6:0], fb};
    endtask

    task automatic send_clean(input int n);
        logic fb;
        for (int i = 0; i < n; i++) begin
            gen_next(fb);
            drive(1'b1, fb);
        end
    endtask

    task automatic send_err();
        logic fb;
        gen_next(fb);
        drive(1'b1, ~fb);
    endtask

    task automatic send_gappy(input int n);
        logic fb;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)));
            gen_next(fb);
            drive(1'b1, fb);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.clear_cnt = 1'b0;
        gen_r   = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulse_cnt = 0;
        lock_seen = 0;
    endtask

    initial begin
        do_reset();
        check("reset_locked", 32'(bus.locked), 32'd0);
        check("reset_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("reset_err_count", 32'(bus.err_count), 32'd0);

        // Error-free acquisition from seed 0: lock after bit 24.
        send_clean(23);
        check("lock_not_before_24", 32'(bus.locked), 32'd0);
        send_clean(1);
        check("lock_at_24", 32'(bus.locked), 32'd1);
        send_clean(976);
        check("clean_1000_err_count", 32'(bus.err_count), 32'd0);
        check("clean_1000_pulses", 32'(pulse_cnt), 32'd0);
        check("clean_1000_locked", 32'(bus.locked), 32'd1);

        // Single error at bit 1001.
        send_err();
        check("single_err_pulse", 32'(bus.err_pulse), 32'd1);
        check("single_err_count", 32'(bus.err_count), 32'd1);
        check("single_err_locked", 32'(bus.locked), 32'd1);
        pulse_cnt = 0;
        send_clean(48);
        check("single_no_more_pulses", 32'(pulse_cnt), 32'd0);
        check("single_count_holds", 32'(bus.err_count), 32'd1);

        // clear_cnt with a simultaneous error at bit 1050.
        bus.clear_cnt = 1'b1;
        send_err();
        bus.clear_cnt = 1'b0;
        check("clear_err_pulse", 32'(bus.err_pulse), 32'd1);
        check("clear_wins_count", 32'(bus.err_count), 32'd0);
        send_clean(61);

        // Four errors at bits 1112,1117,1122,1127 inside one window.
        for (int i = 0; i < 4; i++) begin
            send_err();
            check("loss_err_pulse", 32'(bus.err_pulse), 32'd1);
            if (i < 3) begin
                check("loss_still_locked", 32'(bus.locked), 32'd1);
                send_clean(4);
            end
        end
        check("loss_unlocked", 32'(bus.locked), 32'd0);
        check("loss_err_count", 32'(bus.err_count), 32'd4);
`ifdef LFSR_CHECKER_BITCNT_EN
        check("bitcnt_after_loss", bus.bit_count, 32'd77);
`endif

        // Relock on clean stream after 24 bits; err_count holds.
        send_clean(23);
        check("relock_not_before_24", 32'(bus.locked), 32'd0);
        send_clean(1);
        check("relock_at_24", 32'(bus.locked), 32'd1);
        check("relock_err_count_held", 32'(bus.err_count), 32'd4);
`ifdef LFSR_CHECKER_BITCNT_EN
        check("bitcnt_after_relock", bus.bit_count, 32'd77);
        send_clean(10);
        check("bitcnt_locked_bits", bus.bit_count, 32'd87);
`endif

        // Reset asserted between edges while LOCKED clears outputs at once.
        send_err();
        check("pre_reset_pulse", 32'(bus.err_pulse), 32'd1);
        check("pre_reset_count", 32'(bus.err_count), 32'd5);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_locked", 32'(bus.locked), 32'd0);
        check("async_reset_pulse", 32'(bus.err_pulse), 32'd0);
        check("async_reset_count", 32'(bus.err_count), 32'd0);

        // Stuck-at-1 line never locks.
        do_reset();
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b1);
        check("lockup_never_locked", 32'(lock_seen), 32'd0);
        check("lockup_err_count", 32'(bus.err_count), 32'd0);

        // Error at acquisition bit 12; lock 24 bits after resync (bit 36).
        do_reset();
        send_clean(11);
        send_err();
        send_clean(23);
        check("verify_fail_not_locked", 32'(bus.locked), 32'd0);
        send_clean(1);
        check("verify_fail_relock", 32'(bus.locked), 32'd1);

        // Random in_valid gaps give the same lock point and ignore gap bits.
        do_reset();
        send_gappy(23);
        drive(1'b0, 1'b0);
        check("gap_not_before_24", 32'(bus.locked), 32'd0);
        send_gappy(1);
        check("gap_lock_at_24", 32'(bus.locked), 32'd1);
        drive(1'b0, ~(~(gen_r[7] ^ gen_r[3])));
        check("gap_bit_ignored_pulse", 32'(bus.err_pulse), 32'd0);
        check("gap_locked_hold", 32'(bus.locked), 32'd1);
        pulse_cnt = 0;
        send_gappy(100);
        check("gap_clean_pulses", 32'(pulse_cnt), 32'd0);
        check("gap_clean_err_count", 32'(bus.err_count), 32'd0);
        check("gap_still_locked", 32'(bus.locked), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
